// File: rtl/aegnn.sv
// Shared AEGNN definitions: grid geometry, linear-layer output width and the
// FC scheduler state encoding.
package aegnn;

    localparam int unsigned GRID_NUM     = 12;
    localparam int unsigned GRID_IDX_W   = 4;
    localparam int unsigned FC_OUT_WIDTH = 16;

    typedef logic [GRID_IDX_W-1:0] grid_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } fc_sched_state_e;

    // Increment a grid index, wrapping to 0 at n.
    function automatic grid_idx_t grid_next(input grid_idx_t idx, input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + grid_idx_t'(1);
    endfunction

endpackage

// File: rtl/fc_rr_pick.sv
// Round-robin picker: lowest set bit at or above the pointer, otherwise the
// lowest set bit overall (wrap-around).
module fc_rr_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  i_bitmap,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [IW-1:0] o_sel
);

    logic [N-1:0]  w_masked;
    logic [IW-1:0] w_sel_masked;
    logic [IW-1:0] w_sel_any;

    // Keep only the requests at or above the pointer.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < N; i++) begin
            w_masked[i] = i_bitmap[i] && (32'(i) >= 32'(i_ptr));
        end
    end

    // Two priority encoders; descending scan leaves the lowest index selected.
    always_comb begin
        w_sel_masked = '0;
        w_sel_any    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_sel_masked = IW'(i);
            end
            if (i_bitmap[i]) begin
                w_sel_any = IW'(i);
            end
        end
    end

    assign o_any = |i_bitmap;
    assign o_sel = (|w_masked) ? w_sel_masked : w_sel_any;

endmodule

// File: rtl/fc_grid_scheduler.sv
// Event-driven scheduler for the shared linear layer. Deduplicates grid-update
// requests into a pending bitmap, serves grids round-robin one linear pass at a
// time and returns each pass's output tagged with its grid index.
// Optional WAIT watchdog: define FC_SCHED_TIMEOUT_EN.
module fc_grid_scheduler
    import aegnn::*;
#(
    parameter int unsigned N_GRID         = GRID_NUM,
    parameter int unsigned FC_OUT_C       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             event_stream_clean,
    input  logic                             upd_valid,
    input  grid_idx_t                        upd_grid_idx,
    output logic                             fc_module_start,
    output grid_idx_t                        fc_grid_idx,
    input  logic                             fc_module_done,
    input  logic                             fc_out_valid,
    input  logic [FC_OUT_C*FC_OUT_WIDTH-1:0] fc_out_pack,
    output logic                             result_valid,
    output grid_idx_t                        result_grid_idx,
    output logic [FC_OUT_C*FC_OUT_WIDTH-1:0] result_pack,
    output logic [N_GRID-1:0]                pending,
    output logic                             idle,
    output logic                             timeout_err
);

    localparam int unsigned PackW = FC_OUT_C * FC_OUT_WIDTH;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fc_sched_state_e r_state;
    fc_sched_state_e w_state_d;
    logic [N_GRID-1:0] r_pending;
    logic [N_GRID-1:0] w_pending_d;
    logic [N_GRID-1:0] w_set;
    logic [N_GRID-1:0] w_clr;
    grid_idx_t         r_rr_ptr;
    grid_idx_t         w_rr_ptr_d;
    grid_idx_t         r_grid_idx;
    grid_idx_t         w_grid_idx_d;
    logic              r_result_valid;
    grid_idx_t         r_result_grid;
    logic [PackW-1:0]  r_result_pack;
    logic              r_idle;
    logic              w_idle_d;
    logic              w_capture;
    logic              w_any;
    grid_idx_t         w_sel;
    logic              w_timeout_hit;

    fc_rr_pick #(
        .N  (N_GRID),
        .IW (GRID_IDX_W)
    ) u_rr_pick (
        .i_bitmap (r_pending),
        .i_ptr    (r_rr_ptr),
        .o_any    (w_any),
        .o_sel    (w_sel)
    );

    // Decode an incoming request; out-of-range indices match no bit.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < N_GRID; i++) begin
            w_set[i] = upd_valid && (32'(upd_grid_idx) == 32'(i));
        end
    end

    // Next-state logic: pick, start, wait for the linear pass.
    always_comb begin
        w_state_d    = r_state;
        w_clr        = '0;
        w_grid_idx_d = r_grid_idx;
        w_rr_ptr_d   = r_rr_ptr;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_clr[w_sel] = 1'b1;
                    w_grid_idx_d = w_sel;
                    w_state_d    = START;
                end
            end
            START: begin
                w_state_d = WAIT;
            end
            WAIT: begin
                if (fc_module_done) begin
                    w_capture  = fc_out_valid;
                    w_rr_ptr_d = grid_next(r_grid_idx, N_GRID);
                    w_state_d  = IDLE;
                end else if (w_timeout_hit) begin
                    // Abandoned pass: no result and the grid is not re-queued.
                    w_rr_ptr_d = grid_next(r_grid_idx, N_GRID);
                    w_state_d  = IDLE;
                end else begin
                    w_capture = fc_out_valid;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        // A set on the bit being picked wins so the grid is served again.
        w_pending_d = (r_pending & ~w_clr) | w_set;
        w_idle_d    = (w_state_d == IDLE) && (w_pending_d == '0);
    end

    // State, bitmap and result registers; clean acts exactly like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_grid_idx     <= '0;
            r_result_valid <= 1'b0;
            r_result_grid  <= '0;
            r_result_pack  <= '0;
            r_idle         <= 1'b1;
        end else if (event_stream_clean) begin
            r_state        <= IDLE;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_grid_idx     <= '0;
            r_result_valid <= 1'b0;
            r_result_grid  <= '0;
            r_result_pack  <= '0;
            r_idle         <= 1'b1;
        end else begin
            r_state        <= w_state_d;
            r_pending      <= w_pending_d;
            r_rr_ptr       <= w_rr_ptr_d;
            r_grid_idx     <= w_grid_idx_d;
            r_result_valid <= w_capture;
            r_idle         <= w_idle_d;
            if (w_capture) begin
                r_result_grid <= r_grid_idx;
                r_result_pack <= fc_out_pack;
            end
        end
    end

`ifdef FC_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_wait_cnt;
    logic            r_timeout;

    assign w_timeout_hit = (r_state == WAIT) && (r_wait_cnt == CntW'(TIMEOUT_CYCLES - 1));

    // WAIT dwell counter (restarted in START) and sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (event_stream_clean) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT && !w_timeout_hit) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_timeout <= r_timeout | (w_timeout_hit && !fc_module_done);
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign fc_module_start = (r_state == START);
    assign fc_grid_idx     = r_grid_idx;
    assign result_valid    = r_result_valid;
    assign result_grid_idx = r_result_grid;
    assign result_pack     = r_result_pack;
    assign pending         = r_pending;
    assign idle            = r_idle;

endmodule

// File: tb/tb_fc_grid_scheduler.sv
// Self-checking bench for fc_grid_scheduler: directed scenarios plus a random
// run against a transaction-level round-robin model.
module tb_fc_grid_scheduler;
    import aegnn::*;

    localparam int N  = GRID_NUM;
    localparam int PW = 2 * FC_OUT_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            event_stream_clean;
    logic            upd_valid;
    grid_idx_t       upd_grid_idx;
    logic            fc_module_start;
    grid_idx_t       fc_grid_idx;
    logic            fc_module_done;
    logic            fc_out_valid;
    logic [PW-1:0]   fc_out_pack;
    logic            result_valid;
    grid_idx_t       result_grid_idx;
    logic [PW-1:0]   result_pack;
    logic [N-1:0]    pending;
    logic            idle;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;

    fc_grid_scheduler #(
        .N_GRID         (N),
        .FC_OUT_C       (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .event_stream_clean (event_stream_clean),
        .upd_valid          (upd_valid),
        .upd_grid_idx       (upd_grid_idx),
        .fc_module_start    (fc_module_start),
        .fc_grid_idx        (fc_grid_idx),
        .fc_module_done     (fc_module_done),
        .fc_out_valid       (fc_out_valid),
        .fc_out_pack        (fc_out_pack),
        .result_valid       (result_valid),
        .result_grid_idx    (result_grid_idx),
        .result_pack        (result_pack),
        .pending            (pending),
        .idle               (idle),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference round-robin choice: first set bit at or after ptr, wrapping.
    function automatic int model_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic req(input int idx);
        upd_valid    = 1'b1;
        upd_grid_idx = grid_idx_t'(idx);
        @(negedge clk);
        upd_valid    = 1'b0;
    endtask

    task automatic pulse_done();
        fc_module_done = 1'b1;
        @(negedge clk);
        fc_module_done = 1'b0;
    endtask

    task automatic wait_start(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            if (fc_module_start === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; event_stream_clean = 1'b0; upd_valid = 1'b0; upd_grid_idx = '0;
        fc_module_done = 1'b0; fc_out_valid = 1'b0; fc_out_pack = '0;
        repeat (2) @(negedge clk);
        checks++; if (fc_module_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b exp 0", fc_module_start); end
        checks++; if (fc_grid_idx !== '0) begin errors++; $display("FAIL reset_grid: got %0d exp 0", fc_grid_idx); end
        checks++; if (result_valid !== 1'b0 || result_grid_idx !== '0 || result_pack !== '0) begin
            errors++; $display("FAIL reset_result: got v=%b g=%0d p=%h exp 0", result_valid, result_grid_idx, result_pack); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h exp 0", pending); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", idle); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] e;
        e = '0; e[5] = 1'b1;
        req(5);
        checks++; if (pending !== e || idle !== 1'b0 || fc_module_start !== 1'b0) begin
            errors++; $display("FAIL single_pending: got p=%h idle=%b st=%b exp p=%h idle=0 st=0", pending, idle, fc_module_start, e); end
        @(negedge clk);
        checks++; if (fc_module_start !== 1'b1 || fc_grid_idx !== 4'd5 || pending !== '0) begin
            errors++; $display("FAIL single_start: got st=%b g=%0d p=%h exp st=1 g=5 p=0", fc_module_start, fc_grid_idx, pending); end
        @(negedge clk);
        checks++; if (fc_module_start !== 1'b0 || fc_grid_idx !== 4'd5) begin
            errors++; $display("FAIL single_pulse: got st=%b g=%0d exp st=0 g=5", fc_module_start, fc_grid_idx); end
        fc_out_valid = 1'b1; fc_out_pack = 32'h0012_0034;
        @(negedge clk);
        fc_out_valid = 1'b0; fc_out_pack = '0;
        checks++; if (result_valid !== 1'b1 || result_grid_idx !== 4'd5 || result_pack !== 32'h0012_0034) begin
            errors++; $display("FAIL single_result: got v=%b g=%0d p=%h exp v=1 g=5 p=00120034", result_valid, result_grid_idx, result_pack); end
        pulse_done();
        checks++; if (result_valid !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL single_idle: got v=%b idle=%b exp v=0 idle=1", result_valid, idle); end
    endtask

    task automatic test_invalid_idx();
        upd_valid = 1'b1; upd_grid_idx = grid_idx_t'(N);
        @(negedge clk);
        upd_grid_idx = 4'd15;
        @(negedge clk);
        upd_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (pending !== '0 || fc_module_start !== 1'b0 || idle !== 1'b1) begin
                errors++; $display("FAIL invalid_idx: got p=%h st=%b idle=%b exp p=0 st=0 idle=1", pending, fc_module_start, idle); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int order [4] = '{1, 3, 7, 0};
        logic [N-1:0] e;
        req(11);                       // rr_ptr=6 -> 11, afterwards rr_ptr wraps to 0
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd11) begin
            errors++; $display("FAIL rr_first: got ok=%b g=%0d exp ok=1 g=11", ok, fc_grid_idx); end
        @(negedge clk);
        req(3); req(1); req(7);
        pulse_done();
        e = '0; e[1] = 1'b1; e[3] = 1'b1; e[7] = 1'b1;
        checks++; if (pending !== e) begin errors++; $display("FAIL rr_burst_pending: got %h exp %h", pending, e); end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req(0);        // rr_ptr is 8 here; grid 0 needs a wrap
            wait_start(6, ok);
            checks++; if (!ok || int'(fc_grid_idx) !== order[k]) begin
                errors++; $display("FAIL rr_order%0d: got ok=%b g=%0d exp %0d", k, ok, fc_grid_idx, order[k]); end
            @(negedge clk);
            pulse_done();
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle: got %b exp 1", idle); end
    endtask

    task automatic test_dedup();
        bit ok;
        req(9);                        // rr_ptr=1 -> 9
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd9) begin errors++; $display("FAIL dedup_first: got ok=%b g=%0d exp 9", ok, fc_grid_idx); end
        @(negedge clk);
        req(2); req(2); req(2);
        pulse_done();
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd2) begin errors++; $display("FAIL dedup_pick: got ok=%b g=%0d exp 2", ok, fc_grid_idx); end
        @(negedge clk);
        upd_valid = 1'b1; upd_grid_idx = 4'd2;
        fc_out_valid = 1'b1; fc_out_pack = 32'hAAAA_0001;
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (result_valid !== 1'b1 || result_pack !== 32'hAAAA_0001) begin
            errors++; $display("FAIL dedup_res1: got v=%b p=%h exp v=1 p=aaaa0001", result_valid, result_pack); end
        fc_out_pack = 32'h5555_0002;
        @(negedge clk);
        fc_out_valid = 1'b0;
        checks++; if (result_valid !== 1'b1 || result_pack !== 32'h5555_0002 || result_grid_idx !== 4'd2) begin
            errors++; $display("FAIL dedup_res2: got v=%b g=%0d p=%h exp v=1 g=2 p=55550002", result_valid, result_grid_idx, result_pack); end
        pulse_done();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL dedup_res_pulse: got %b exp 0", result_valid); end
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd2) begin errors++; $display("FAIL dedup_requeue: got ok=%b g=%0d exp 2", ok, fc_grid_idx); end
        @(negedge clk);
        pulse_done();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL dedup_noresult: got %b exp 0", result_valid); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (fc_module_start !== 1'b0 || idle !== 1'b1) begin
                errors++; $display("FAIL dedup_single_pass: got st=%b idle=%b exp st=0 idle=1", fc_module_start, idle); end
            @(negedge clk);
        end
    endtask

    task automatic test_pick_collision();
        bit ok;
        logic [N-1:0] e;
        upd_valid = 1'b1; upd_grid_idx = 4'd10;
        @(negedge clk);                // pick cycle for grid 10: request it again
        @(negedge clk);
        upd_valid = 1'b0;
        e = '0; e[10] = 1'b1;
        checks++; if (fc_module_start !== 1'b1 || fc_grid_idx !== 4'd10 || pending !== e) begin
            errors++; $display("FAIL collision_setwins: got st=%b g=%0d p=%h exp st=1 g=10 p=%h", fc_module_start, fc_grid_idx, pending, e); end
        @(negedge clk);
        pulse_done();
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd10) begin errors++; $display("FAIL collision_again: got ok=%b g=%0d exp 10", ok, fc_grid_idx); end
        @(negedge clk);
        pulse_done();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL collision_idle: got %b exp 1", idle); end
    endtask

    task automatic test_clean();
        bit ok;
        int starts;
        req(8);
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd8) begin errors++; $display("FAIL clean_first: got ok=%b g=%0d exp 8", ok, fc_grid_idx); end
        @(negedge clk);
        req(4); req(6);
        event_stream_clean = 1'b1; fc_out_valid = 1'b1; fc_out_pack = 32'hDEAD_BEEF;
        @(negedge clk);
        event_stream_clean = 1'b0; fc_out_valid = 1'b0;
        checks++; if (pending !== '0 || idle !== 1'b1 || result_valid !== 1'b0 || fc_module_start !== 1'b0) begin
            errors++; $display("FAIL clean_state: got p=%h idle=%b v=%b st=%b exp p=0 idle=1 v=0 st=0", pending, idle, result_valid, fc_module_start); end
        starts = 0;
        for (int c = 0; c < 8; c++) begin
            fc_module_done = (c == 2);
            if (fc_module_start === 1'b1 || result_valid === 1'b1) starts++;
            @(negedge clk);
        end
        fc_module_done = 1'b0;
        checks++; if (starts !== 0) begin errors++; $display("FAIL clean_quiet: got %0d activity cycles exp 0", starts); end
    endtask

    task automatic test_timeout();
        bit ok;
        int starts;
        req(3);
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd3) begin errors++; $display("FAIL to_first: got ok=%b g=%0d exp 3", ok, fc_grid_idx); end
        @(negedge clk);
        req(7);
        starts = 0;
        for (int c = 1; c < 16; c++) begin   // WAIT cycles 2..16, done withheld
            if (fc_module_start === 1'b1 || result_valid === 1'b1) starts++;
            @(negedge clk);
        end
`ifdef FC_SCHED_TIMEOUT_EN
        checks++; if (timeout_err !== 1'b1 || starts !== 0) begin
            errors++; $display("FAIL to_flag: got err=%b activity=%0d exp err=1 activity=0", timeout_err, starts); end
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd7) begin errors++; $display("FAIL to_next: got ok=%b g=%0d exp 7", ok, fc_grid_idx); end
        @(negedge clk);
        pulse_done();
        checks++; if (idle !== 1'b1 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky: got idle=%b err=%b exp idle=1 err=1", idle, timeout_err); end
        event_stream_clean = 1'b1;
        @(negedge clk);
        event_stream_clean = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b exp 0", timeout_err); end
`else
        repeat (8) begin
            if (fc_module_start === 1'b1 || result_valid === 1'b1) starts++;
            @(negedge clk);
        end
        checks++; if (timeout_err !== 1'b0 || starts !== 0 || idle !== 1'b0) begin
            errors++; $display("FAIL to_off: got err=%b activity=%0d idle=%b exp err=0 activity=0 idle=0", timeout_err, starts, idle); end
        pulse_done();
        wait_start(4, ok);
        checks++; if (!ok || fc_grid_idx !== 4'd7) begin errors++; $display("FAIL to_off_next: got ok=%b g=%0d exp 7", ok, fc_grid_idx); end
        @(negedge clk);
        pulse_done();
`endif
    endtask

    task automatic test_random();
        logic [N-1:0] m_pend;
        logic [PW-1:0] p;
        int m_ptr, exp, mode, nreq, nval, idx;
        bit ok;
        event_stream_clean = 1'b1;
        @(negedge clk);
        event_stream_clean = 1'b0;
        m_pend = '0; m_ptr = 0;
        for (int it = 0; it < 60; it++) begin
            if (m_pend == '0) begin
                if ($urandom_range(0, 2) == 0) req($urandom_range(N, 15));
                idx = $urandom_range(0, N - 1);
                req(idx);
                m_pend[idx] = 1'b1;
            end
            wait_start(6, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_start%0d: no start seen", it); break; end
            exp = model_pick(m_pend, m_ptr);
            m_pend[exp] = 1'b0;
            checks++; if (int'(fc_grid_idx) !== exp || pending !== m_pend) begin
                errors++; $display("FAIL rand_pick%0d: got g=%0d p=%h exp g=%0d p=%h", it, fc_grid_idx, pending, exp, m_pend); end
            @(negedge clk);
            nreq = $urandom_range(0, 3);
            for (int k = 0; k < nreq; k++) begin
                idx = $urandom_range(0, 15);
                if (idx < N) m_pend[idx] = 1'b1;
                req(idx);
            end
            mode = $urandom_range(0, 3);
            nval = (mode == 0) ? 0 : (mode == 2) ? 2 : 1;
            for (int v = 0; v < nval; v++) begin
                p = PW'($urandom);
                fc_out_valid = 1'b1; fc_out_pack = p;
                fc_module_done = (mode == 3);
                @(negedge clk);
                fc_out_valid = 1'b0; fc_module_done = 1'b0;
                checks++; if (result_valid !== 1'b1 || int'(result_grid_idx) !== exp || result_pack !== p) begin
                    errors++; $display("FAIL rand_result%0d: got v=%b g=%0d p=%h exp v=1 g=%0d p=%h",
                                       it, result_valid, result_grid_idx, result_pack, exp, p); end
            end
            if (mode != 3) begin
                pulse_done();
                checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rand_nores%0d: got %b exp 0", it, result_valid); end
            end
            m_ptr = (exp + 1) % N;
            if (m_pend == '0) begin
                checks++; if (idle !== 1'b1 || pending !== '0) begin
                    errors++; $display("FAIL rand_idle%0d: got idle=%b p=%h exp idle=1 p=0", it, idle, pending); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid_idx();
        test_round_robin();
        test_dedup();
        test_pick_collision();
        test_clean();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
